// File: rtl/uart_axi_write_sequencer_pkg.sv
// Shared types and constants for the UART-to-AXI4-Lite write sequencer.
// State encoding, AXI response codes and interrupt status bit positions.
package uart_axi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR_DATA,
        S_RESP
    } wr_seq_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         IRQ_BRESP = 0;
    localparam int         IRQ_FRAME = 1;
    localparam int         IRQ_OVF   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO. Head entry is visible combinationally; one cycle from push to non-empty.
// No internal overflow guard: the caller only pushes when not full or when popping in the same cycle.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 34,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    // Pointers wrap naturally; DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head_dat = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);

endmodule

// File: rtl/uart_axi_write_sequencer.sv
// Buffers receiver words and writes each as one AXI4-Lite AW/W/B transaction; push to AWVALID 2 cycles.
// Receiver is throttled via uart_enable; words arriving to a full buffer are dropped and flagged.
module uart_axi_write_sequencer
    import uart_axi_pkg::*;
#(
    parameter int                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter int                          MEMORY_ADDR_WIDTH  = 18,
    parameter int                          MEMORY_DATA_WIDTH  = 16,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = 32'h0000_0000,
    parameter int                          FIFO_DEPTH         = 4,
    parameter int                          SKID               = 2
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            word_we_n,
    input  logic [MEMORY_ADDR_WIDTH-1:0]    word_addr,
    input  logic [MEMORY_DATA_WIDTH-1:0]    word_data,
    input  logic                            frame_error,
    output logic                            uart_enable,
    input  logic                            irq_clear,
    output logic [2:0]                      irq_status,
    output logic                            Interrupt,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    localparam int ENTRY_W = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] ENA_LIMIT = CNT_W'(FIFO_DEPTH - SKID - 1);

    wr_seq_state_t                   r_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]                      r_wstrb;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_bready;
    logic                            r_uart_enable;
    logic [2:0]                      r_irq_status;
    logic                            r_interrupt;
    logic                            r_frame_d;

    logic                            w_push_req;
    logic                            w_accept;
    logic                            w_pop;
    logic                            w_full;
    logic                            w_empty;
    logic [CNT_W-1:0]                w_count;
    logic [ENTRY_W-1:0]              w_head;
    logic [MEMORY_ADDR_WIDTH-1:0]    w_head_addr;
    logic [MEMORY_DATA_WIDTH-1:0]    w_head_data;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_awaddr;
    logic [3:0]                      w_wstrb;
    logic                            w_aw_done;
    logic                            w_w_done;
    logic [2:0]                      w_irq_set;

    // The head entry stays in the buffer until its B response, so count covers the in-flight word.
    assign w_push_req = !word_we_n;
    assign w_pop      = (r_state == S_RESP) && M_AXI_BVALID;
    assign w_accept   = w_push_req && (!w_full || w_pop);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (M_AXI_ACLK),
        .rst_n      (M_AXI_ARESETN),
        .i_push     (w_accept),
        .i_dat      ({word_addr, word_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_head_addr = w_head[ENTRY_W-1 -: MEMORY_ADDR_WIDTH];
    assign w_head_data = w_head[MEMORY_DATA_WIDTH-1:0];
    assign w_awaddr    = C_BASE_ADDR
                       + {{(C_M_AXI_ADDR_WIDTH-MEMORY_ADDR_WIDTH-1){1'b0}}, w_head_addr, 1'b0};
    assign w_wstrb     = w_awaddr[1] ? 4'b1100 : 4'b0011;
    assign w_aw_done   = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done    = !r_wvalid  || M_AXI_WREADY;

    always_comb begin
        w_irq_set            = '0;
        w_irq_set[IRQ_BRESP] = w_pop && (M_AXI_BRESP != RESP_OKAY);
        w_irq_set[IRQ_FRAME] = frame_error && !r_frame_d;
        w_irq_set[IRQ_OVF]   = w_push_req && !w_accept;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state   <= S_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_awaddr  <= w_awaddr;
                        r_wdata   <= {2{w_head_data}};
                        r_wstrb   <= w_wstrb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_ADDR_DATA;
                    end
                end
                S_ADDR_DATA: begin
                    if (M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A set in the same cycle as irq_clear survives the clear.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_uart_enable <= 1'b1;
            r_irq_status  <= '0;
            r_interrupt   <= 1'b0;
            r_frame_d     <= 1'b0;
        end else begin
            r_uart_enable <= (w_count <= ENA_LIMIT);
            r_irq_status  <= irq_clear ? w_irq_set : (r_irq_status | w_irq_set);
            r_interrupt   <= |r_irq_status;
            r_frame_d     <= frame_error;
        end
    end

    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign uart_enable   = r_uart_enable;
    assign irq_status    = r_irq_status;
    assign Interrupt     = r_interrupt;

endmodule

// File: tb/tb_uart_axi_write_sequencer.sv
// Directed bench for uart_axi_write_sequencer: one task per scenario, inline checks against hand-computed values.
module tb_uart_axi_write_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        word_we_n = 1'b1;
    logic [17:0] word_addr = '0;
    logic [15:0] word_data = '0;
    logic        frame_error = 1'b0;
    logic        uart_enable;
    logic        irq_clear = 1'b0;
    logic [2:0]  irq_status;
    logic        Interrupt;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;

    int checks = 0;
    int failures = 0;

    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, stab_err = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0;
    logic        aw_pend = 1'b0, w_pend = 1'b0;
    logic [31:0] hold_awaddr = '0, hold_wdata = '0;
    logic [3:0]  hold_wstrb = '0;

    uart_axi_write_sequencer dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .word_we_n     (word_we_n),
        .word_addr     (word_addr),
        .word_data     (word_data),
        .frame_error   (frame_error),
        .uart_enable   (uart_enable),
        .irq_clear     (irq_clear),
        .irq_status    (irq_status),
        .Interrupt     (Interrupt),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    always #5 clk = ~clk;

    // Handshake counter and payload-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            if (aw_pend && (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== hold_awaddr))
                stab_err <= stab_err + 1;
            if (w_pend && (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== hold_wdata || M_AXI_WSTRB !== hold_wstrb))
                stab_err <= stab_err + 1;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_cnt      <= aw_cnt + 1;
                last_awaddr <= M_AXI_AWADDR;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_cnt      <= w_cnt + 1;
                last_wdata <= M_AXI_WDATA;
            end
            if (M_AXI_BVALID && M_AXI_BREADY)
                b_cnt <= b_cnt + 1;
            aw_pend     <= M_AXI_AWVALID && !M_AXI_AWREADY;
            w_pend      <= M_AXI_WVALID && !M_AXI_WREADY;
            hold_awaddr <= M_AXI_AWADDR;
            hold_wdata  <= M_AXI_WDATA;
            hold_wstrb  <= M_AXI_WSTRB;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] a, input logic [15:0] d);
        word_we_n = 1'b0;
        word_addr = a;
        word_data = d;
        tick();
        word_we_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL reset_awvalid: got %b expected 0", M_AXI_AWVALID); end
        checks++; if (M_AXI_WVALID !== 1'b0) begin failures++; $display("FAIL reset_wvalid: got %b expected 0", M_AXI_WVALID); end
        checks++; if (M_AXI_BREADY !== 1'b0) begin failures++; $display("FAIL reset_bready: got %b expected 0", M_AXI_BREADY); end
        checks++; if (M_AXI_AWADDR !== 32'h0) begin failures++; $display("FAIL reset_awaddr: got %h expected 0", M_AXI_AWADDR); end
        checks++; if (irq_status !== 3'b000) begin failures++; $display("FAIL reset_irq: got %b expected 000", irq_status); end
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL reset_int: got %b expected 0", Interrupt); end
        checks++; if (uart_enable !== 1'b1) begin failures++; $display("FAIL reset_uart_en: got %b expected 1", uart_enable); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        int aw0, b0;
        aw0 = aw_cnt; b0 = b_cnt;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b0;
        push(18'h00003, 16'hBEEF);
        checks++; if (M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL single_lat1: got %b expected 0", M_AXI_AWVALID); end
        tick();
        checks++; if (M_AXI_AWVALID !== 1'b1 || M_AXI_WVALID !== 1'b1) begin failures++; $display("FAIL single_lat2: got aw=%b w=%b expected 1 1", M_AXI_AWVALID, M_AXI_WVALID); end
        checks++; if (M_AXI_AWADDR !== 32'h6) begin failures++; $display("FAIL single_awaddr: got %h expected 00000006", M_AXI_AWADDR); end
        checks++; if (M_AXI_WDATA !== 32'hBEEFBEEF) begin failures++; $display("FAIL single_wdata: got %h expected beefbeef", M_AXI_WDATA); end
        checks++; if (M_AXI_WSTRB !== 4'b1100) begin failures++; $display("FAIL single_wstrb: got %b expected 1100", M_AXI_WSTRB); end
        tick();
        checks++; if (M_AXI_BREADY !== 1'b1 || M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL single_resp: got bready=%b aw=%b expected 1 0", M_AXI_BREADY, M_AXI_AWVALID); end
        M_AXI_BVALID = 1'b1;
        tick();
        M_AXI_BVALID = 1'b0;
        checks++; if (M_AXI_BREADY !== 1'b0) begin failures++; $display("FAIL single_bready_clr: got %b expected 0", M_AXI_BREADY); end
        repeat (4) tick();
        checks++; if (aw_cnt - aw0 !== 1 || b_cnt - b0 !== 1) begin failures++; $display("FAIL single_count: got aw=%0d b=%0d expected 1 1", aw_cnt - aw0, b_cnt - b0); end
        checks++; if (M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL single_empty: got %b expected 0", M_AXI_AWVALID); end
    endtask

    task automatic test_stalls();
        int aw0, w0, b0, s0;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; s0 = stab_err;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b1;
        push(18'h00010, 16'h1234);
        for (int i = 0; i < 10 && M_AXI_AWVALID !== 1'b1; i++) tick();
        checks++; if (M_AXI_AWVALID !== 1'b1) begin failures++; $display("FAIL stall_aw_start: got %b expected 1", M_AXI_AWVALID); end
        tick();
        checks++; if (M_AXI_WVALID !== 1'b0 || M_AXI_AWVALID !== 1'b1) begin failures++; $display("FAIL stall_w_first: got w=%b aw=%b expected 0 1", M_AXI_WVALID, M_AXI_AWVALID); end
        repeat (3) tick();
        checks++; if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 32'h20 || M_AXI_BREADY !== 1'b0) begin failures++; $display("FAIL stall_aw_hold: got aw=%b addr=%h bready=%b expected 1 00000020 0", M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_BREADY); end
        M_AXI_AWREADY = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0;
        checks++; if (M_AXI_AWVALID !== 1'b0 || M_AXI_BREADY !== 1'b1) begin failures++; $display("FAIL stall_aw_done: got aw=%b bready=%b expected 0 1", M_AXI_AWVALID, M_AXI_BREADY); end
        M_AXI_BVALID = 1'b1; tick(); M_AXI_BVALID = 1'b0;
        M_AXI_WREADY = 1'b0; M_AXI_AWREADY = 1'b1;
        push(18'h20001, 16'hA5C3);
        for (int i = 0; i < 10 && M_AXI_WVALID !== 1'b1; i++) tick();
        tick();
        checks++; if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b1) begin failures++; $display("FAIL stall_aw_first: got aw=%b w=%b expected 0 1", M_AXI_AWVALID, M_AXI_WVALID); end
        repeat (3) tick();
        checks++; if (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== 32'hA5C3A5C3 || M_AXI_WSTRB !== 4'b1100) begin failures++; $display("FAIL stall_w_hold: got w=%b data=%h strb=%b expected 1 a5c3a5c3 1100", M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB); end
        M_AXI_WREADY = 1'b1;
        tick();
        M_AXI_WREADY = 1'b0; M_AXI_AWREADY = 1'b0;
        checks++; if (M_AXI_BREADY !== 1'b1) begin failures++; $display("FAIL stall_w_done: got bready=%b expected 1", M_AXI_BREADY); end
        M_AXI_BVALID = 1'b1; tick(); M_AXI_BVALID = 1'b0;
        repeat (3) tick();
        checks++; if (aw_cnt - aw0 !== 2 || w_cnt - w0 !== 2 || b_cnt - b0 !== 2) begin failures++; $display("FAIL stall_count: got aw=%0d w=%0d b=%0d expected 2 2 2", aw_cnt - aw0, w_cnt - w0, b_cnt - b0); end
        checks++; if (stab_err - s0 !== 0) begin failures++; $display("FAIL stall_stability: got %0d violations expected 0", stab_err - s0); end
        checks++; if (last_awaddr !== 32'h0004_0002) begin failures++; $display("FAIL stall_awaddr2: got %h expected 00040002", last_awaddr); end
    endtask

    task automatic test_backpressure();
        int b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        push(18'h1, 16'h0001);
        push(18'h2, 16'h0002);
        checks++; if (uart_enable !== 1'b1) begin failures++; $display("FAIL bp_enable_lag: got %b expected 1", uart_enable); end
        tick();
        checks++; if (uart_enable !== 1'b0) begin failures++; $display("FAIL bp_enable_drop: got %b expected 0", uart_enable); end
        push(18'h3, 16'h0003);
        push(18'h4, 16'h0004);
        checks++; if (irq_status !== 3'b000) begin failures++; $display("FAIL bp_fourth_ok: got %b expected 000", irq_status); end
        push(18'h5, 16'h0005);
        checks++; if (irq_status !== 3'b100 || Interrupt !== 1'b0) begin failures++; $display("FAIL bp_overflow: got irq=%b int=%b expected 100 0", irq_status, Interrupt); end
        tick();
        checks++; if (Interrupt !== 1'b1) begin failures++; $display("FAIL bp_interrupt: got %b expected 1", Interrupt); end
        irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        checks++; if (irq_status !== 3'b000) begin failures++; $display("FAIL bp_clear_status: got %b expected 000", irq_status); end
        tick();
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL bp_clear_int: got %b expected 0", Interrupt); end
        b0 = b_cnt;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1;
        repeat (30) tick();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        tick();
        checks++; if (b_cnt - b0 !== 4 || uart_enable !== 1'b1) begin failures++; $display("FAIL bp_drain: got b=%0d en=%b expected 4 1", b_cnt - b0, uart_enable); end
    endtask

    task automatic test_full_push_pop();
        int aw0, b0;
        aw0 = aw_cnt; b0 = b_cnt;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b0;
        for (int i = 0; i < 4; i++) push(18'h100 + 18'(i), 16'hC000 + 16'(i));
        checks++; if (M_AXI_BREADY !== 1'b1) begin failures++; $display("FAIL full_bready: got %b expected 1", M_AXI_BREADY); end
        word_we_n = 1'b0; word_addr = 18'h104; word_data = 16'hC004; M_AXI_BVALID = 1'b1;
        tick();
        word_we_n = 1'b1; M_AXI_BVALID = 1'b0;
        checks++; if (irq_status !== 3'b000) begin failures++; $display("FAIL full_pushpop_noovf: got %b expected 000", irq_status); end
        word_we_n = 1'b0; word_addr = 18'h105; word_data = 16'hC005; irq_clear = 1'b1;
        tick();
        word_we_n = 1'b1; irq_clear = 1'b0;
        checks++; if (irq_status !== 3'b100) begin failures++; $display("FAIL full_still4_set_beats_clear: got %b expected 100", irq_status); end
        irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        M_AXI_BVALID = 1'b1;
        repeat (30) tick();
        M_AXI_BVALID = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        tick();
        checks++; if (aw_cnt - aw0 !== 5 || b_cnt - b0 !== 5) begin failures++; $display("FAIL full_count: got aw=%0d b=%0d expected 5 5", aw_cnt - aw0, b_cnt - b0); end
        checks++; if (last_wdata !== 32'hC004C004 || last_awaddr !== 32'h208) begin failures++; $display("FAIL full_last_word: got data=%h addr=%h expected c004c004 00000208", last_wdata, last_awaddr); end
    endtask

    task automatic test_bresp_error();
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b0;
        push(18'h5, 16'h1111);
        push(18'h6, 16'h2222);
        for (int i = 0; i < 10 && M_AXI_BREADY !== 1'b1; i++) tick();
        checks++; if (M_AXI_BREADY !== 1'b1) begin failures++; $display("FAIL bresp_wait1: got %b expected 1", M_AXI_BREADY); end
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
        tick();
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        checks++; if (irq_status !== 3'b001) begin failures++; $display("FAIL bresp_flag: got %b expected 001", irq_status); end
        checks++; if (M_AXI_AWVALID !== 1'b0) begin failures++; $display("FAIL bresp_idle_gap: got %b expected 0", M_AXI_AWVALID); end
        tick();
        checks++; if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== 32'hC || M_AXI_WDATA !== 32'h22222222 || M_AXI_WSTRB !== 4'b0011) begin failures++; $display("FAIL bresp_word2: got aw=%b addr=%h data=%h strb=%b expected 1 0000000c 22222222 0011", M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB); end
        for (int i = 0; i < 10 && M_AXI_BREADY !== 1'b1; i++) tick();
        M_AXI_BVALID = 1'b1; tick(); M_AXI_BVALID = 1'b0;
        checks++; if (irq_status !== 3'b001) begin failures++; $display("FAIL bresp_okay_no_set: got %b expected 001", irq_status); end
        irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        tick();
    endtask

    task automatic test_frame_error();
        frame_error = 1'b1;
        tick();
        checks++; if (irq_status !== 3'b010) begin failures++; $display("FAIL frame_set: got %b expected 010", irq_status); end
        irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        checks++; if (irq_status !== 3'b000) begin failures++; $display("FAIL frame_level_no_reset: got %b expected 000", irq_status); end
        tick();
        checks++; if (Interrupt !== 1'b0) begin failures++; $display("FAIL frame_int_clear: got %b expected 0", Interrupt); end
        frame_error = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int aw0, b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        push(18'h7, 16'h7777);
        for (int i = 0; i < 10 && M_AXI_AWVALID !== 1'b1; i++) tick();
        checks++; if (M_AXI_AWVALID !== 1'b1) begin failures++; $display("FAIL rstmid_start: got %b expected 1", M_AXI_AWVALID); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0) begin failures++; $display("FAIL rstmid_async: got aw=%b w=%b expected 0 0", M_AXI_AWVALID, M_AXI_WVALID); end
        tick(); tick();
        #2 rst_n = 1'b1;
        aw0 = aw_cnt; b0 = b_cnt;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1;
        repeat (5) tick();
        checks++; if (M_AXI_AWVALID !== 1'b0 || aw_cnt - aw0 !== 0 || b_cnt - b0 !== 0) begin failures++; $display("FAIL rstmid_empty: got aw=%b awn=%0d bn=%0d expected 0 0 0", M_AXI_AWVALID, aw_cnt - aw0, b_cnt - b0); end
        checks++; if (uart_enable !== 1'b1) begin failures++; $display("FAIL rstmid_enable: got %b expected 1", uart_enable); end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_stalls();
        test_backpressure();
        test_full_push_pop();
        test_bresp_error();
        test_frame_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
